// File: rtl/chinx_fetch_ctrl.sv
// chinx_fetch_ctrl: instruction-fetch sequencer for the chinx core.
//
// Owns the fetch PC and drives the instruction-memory request/ack handshake.
// Returned instructions go into a 2-entry queue toward decode. Exception and
// branch redirects flush the queue and retarget fetch. A fetch that is still
// in flight when a redirect arrives is let complete, and its data is dropped.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall_i           decode does not consume the queue head this cycle
//   br_valid_i/_target_i, exc_valid_i/_target_i
//                     redirect requests; the exception wins over the branch
//   imem_req_o/addr_o request to instruction memory (address held until ack)
//   imem_ack_i/rdata_i accept + same-cycle data from instruction memory
//   if_valid_o/pc_o/instr_o
//                     head of the fetch queue toward decode
//   fetch_misalign_o  one-cycle pulse when a redirect target is not word aligned
//
// Build option: define CHINX_FETCH_ALIGN_CHK_EN to enable the alignment check.
// With it, misaligned targets are forced to a word boundary and pulse
// fetch_misalign_o. Without it, targets are used as given and
// fetch_misalign_o is tied to 0.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module chinx_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = `ADDR_WIDTH,
  parameter int unsigned       INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              exc_valid_i,
  input  logic [ADDR_W-1:0] exc_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INSN_W-1:0] imem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INSN_W-1:0] if_instr_o,
  output logic              fetch_misalign_o
);

  typedef enum logic [1:0] {StIdle, StReq, StKill} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]   kill_tgt_q, kill_tgt_d;
  logic [1:0]          count_q, count_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   pc_mem_q   [2];
  logic [INSN_W-1:0]   insn_mem_q [2];

  logic                redirect;
  logic [ADDR_W-1:0]   target_raw;
  logic [ADDR_W-1:0]   target;
  logic                pop;
  logic                push;
  logic [2:0]          occ_next;

  assign redirect   = exc_valid_i | br_valid_i;
  assign target_raw = exc_valid_i ? exc_target_i : br_target_i;

`ifdef CHINX_FETCH_ALIGN_CHK_EN
  logic misalign_q;

  assign target = {target_raw[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect && (target_raw[1:0] != 2'b00);
    end
  end

  assign fetch_misalign_o = misalign_q;
`else
  assign target           = target_raw;
  assign fetch_misalign_o = 1'b0;
`endif

  assign pop      = (count_q != 2'd0) && !stall_i;
  // Data returned while a redirect is being applied is stale and never queued.
  assign push     = (state_q == StReq) && imem_ack_i && !redirect;
  assign occ_next = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};

  // Queue occupancy and pointers; a redirect flushes regardless of push/pop.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d = occ_next[1:0];
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
    end
  end

  // Fetch FSM: a request is only started or kept live while the queue can
  // still absorb its data (occ_next <= 1), so the queue cannot overflow.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    kill_tgt_d = kill_tgt_q;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          state_d    = StReq;
          req_addr_d = target;
          fetch_pc_d = target;
        end else if (occ_next <= 3'd1) begin
          state_d    = StReq;
          req_addr_d = fetch_pc_q;
        end
      end
      StReq: begin
        if (imem_ack_i && !redirect) begin
          fetch_pc_d = req_addr_q + ADDR_W'(4);
          if (occ_next <= 3'd1) begin
            req_addr_d = req_addr_q + ADDR_W'(4);
          end else begin
            state_d = StIdle;
          end
        end else if (imem_ack_i) begin
          req_addr_d = target;
          fetch_pc_d = target;
        end else if (redirect) begin
          // Address must stay stable until ack; remember where to go after.
          state_d    = StKill;
          kill_tgt_d = target;
        end
      end
      StKill: begin
        if (imem_ack_i) begin
          state_d    = StReq;
          req_addr_d = redirect ? target : kill_tgt_q;
          fetch_pc_d = redirect ? target : kill_tgt_q;
        end else if (redirect) begin
          kill_tgt_d = target;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      req_addr_q    <= RESET_PC;
      kill_tgt_q    <= RESET_PC;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      pc_mem_q[0]   <= '0;
      pc_mem_q[1]   <= '0;
      insn_mem_q[0] <= '0;
      insn_mem_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      kill_tgt_q <= kill_tgt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= req_addr_q;
        insn_mem_q[wr_ptr_q] <= imem_rdata_i;
      end
    end
  end

  assign imem_req_o  = (state_q != StIdle);
  assign imem_addr_o = req_addr_q;
  assign if_valid_o  = (count_q != 2'd0);
  assign if_pc_o     = pc_mem_q[rd_ptr_q];
  assign if_instr_o  = insn_mem_q[rd_ptr_q];

endmodule

// File: doc/chinx_fetch_ctrl.md
# chinx_fetch_ctrl

Instruction-fetch sequencer for the chinx core. It owns the fetch program counter, issues requests on the instruction-memory handshake, and buffers returned instructions in a 2-entry queue toward decode. It also applies exception and branch redirects, and discards any in-flight fetch made stale by a redirect.

## Interface

Parameters:
- `ADDR_W`, default `` `ADDR_WIDTH ``: width of PC and memory address.
- `INSN_W`, default 32: instruction width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high (`` `LEV_H ``); clears all state immediately.
- `stall_i`  in  1  decode not consuming this cycle.
- `br_valid_i`  in  1  branch redirect request.
- `br_target_i`  in  ADDR_W  branch target.
- `exc_valid_i`  in  1  exception redirect request; has priority over branch.
- `exc_target_i`  in  ADDR_W  exception vector.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  ADDR_W  fetch address; stable while `imem_req_o` is high.
- `imem_ack_i`  in  1  request accepted; data valid in the same cycle.
- `imem_rdata_i`  in  INSN_W  instruction data.
- `if_valid_o`  out  1  queue head valid.
- `if_pc_o`  out  ADDR_W  PC of the queue head.
- `if_instr_o`  out  INSN_W  instruction at the queue head.
- `fetch_misalign_o`  out  1  misaligned redirect pulse; present only with `CHINX_FETCH_ALIGN_CHK_EN`.

## Operation

State registers:
- `fetch_pc` (next address to fetch).
- `req_addr` (drives `imem_addr_o`).
- `kill_target`.
- 2-entry queue with `count` in {0,1,2}.
- FSM with states IDLE_S, REQ_S, KILL_S.

Pop, push and redirect:
- pop = `if_valid_o && !stall_i`.
- push = `imem_ack_i` in REQ_S with no redirect in the same cycle.
- occ_next = count + push − pop.
- redirect = `exc_valid_i || br_valid_i`.
- target = `exc_target_i` when `exc_valid_i` is high, else `br_target_i`.
- A redirect flushes the queue: count becomes 0 on the next edge. The redirect takes precedence over a simultaneous pop or push.

FSM (`imem_req_o` = state is REQ_S or KILL_S):
- IDLE_S:
  - redirect → REQ_S, with `req_addr`/`fetch_pc` ← target.
  - Otherwise, occ_next ≤ 1 → REQ_S, with `req_addr` ← `fetch_pc`.
  - Otherwise stay in IDLE_S.
- REQ_S, with ack and no redirect:
  - Push {`req_addr`, `imem_rdata_i`} and set `fetch_pc` ← `req_addr` + 4.
  - If occ_next ≤ 1, stay in REQ_S with `req_addr` ← `req_addr` + 4 (back-to-back fetch).
  - Otherwise → IDLE_S.
- REQ_S, with ack and redirect: discard the data, stay in REQ_S, `req_addr` ← target.
- REQ_S, with redirect and no ack: → KILL_S, `kill_target` ← target. `req_addr` is held.
- REQ_S, with no ack and no redirect: hold.
- KILL_S:
  - The request stays asserted at the unchanged address until ack.
  - A further redirect overwrites `kill_target`.
  - On ack, discard the data and → REQ_S with `req_addr` ← `kill_target`. A redirect in the ack cycle is used in place of `kill_target`.
- The queue never overflows: a request is only kept live when occ_next ≤ 1.

Arithmetic and wrap rules:
- PC increment is +4, modulo 2^ADDR_W; `'1 - 3` wraps to 0.
- The queue index pointers wrap modulo 2.

## Timing

Reset values:
- State IDLE_S, count 0.
- `fetch_pc` and `req_addr` = `RESET_PC`.
- `imem_req_o` 0, `imem_addr_o` `RESET_PC`.
- `if_valid_o` 0, `if_pc_o` 0, `if_instr_o` 0.
- `fetch_misalign_o` 0.
- Reset mid-request abandons the outstanding fetch; the memory side must tolerate this.

Latencies:
- First `imem_req_o` is high after the 1st rising edge following reset release.
- An ack at edge n makes the instruction visible at `if_*_o` after edge n (1-cycle latency).
- With ack every cycle and no stall, throughput is 1 instruction per cycle.
- Redirect at cycle n with no outstanding request: the request to target is issued after edge n, and `if_valid_o` is 0 after edge n.

All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Configuration

- `CHINX_FETCH_ALIGN_CHK_EN` defined:
  - A redirect target with bits [1:0] ≠ 0 pulses `fetch_misalign_o` for one cycle, coincident with the state update.
  - The redirect proceeds to target & ~3.
- Undefined:
  - Targets are used verbatim.
  - `fetch_misalign_o` is tied to 0.

## Test plan

- Reset, ack held 1, no stall → requests to 0x0, 0x4, 0x8 on consecutive cycles; `if_pc_o` follows one cycle later with `if_valid_o` = 1.
- `stall_i` = 1 from the 2nd instruction onward → queue reaches count 2, `imem_req_o` drops and holds 0; releasing the stall resumes at the next sequential address with no loss or duplication.
- Ack delayed 3 cycles; `br_valid_i` with target 0x100 asserted in the first request cycle → address held until ack, data discarded, next request to 0x100, no `if_valid_o` for the stale fetch.
- `exc_valid_i` (0x80) and `br_valid_i` (0x200) in the same cycle → fetch goes to 0x80.
- `fetch_pc` = 0xFFFF_FFFC (ADDR_W 32) → next fetch 0x0.
- With `CHINX_FETCH_ALIGN_CHK_EN`: branch to 0x102 → one-cycle `fetch_misalign_o` pulse, fetch to 0x100; without the macro, the fetch goes to 0x102 and the pulse stays 0.
